// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// No logic; compile-time definitions only.
// No flow control.
package disp_scan_ctrl_pkg;

  localparam int DISP_SEG_W      = 7;
  localparam int DISP_NUM_DIGITS = 8;

  // Segments gfedcba, active-low.
  typedef logic [DISP_SEG_W-1:0] disp_segment_t;

  // All segments off.
  localparam disp_segment_t DISP_SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/disp_scan_ctrl_decoder.sv
// Hex nibble to active-low gfedcba segment pattern.
// Purely combinational; the caller registers the result.
// No flow control.
module DispDecoder
  import disp_scan_ctrl_pkg::*;
(
  input  logic [3:0]    nibble_i,
  output disp_segment_t seg_o
);

  // Lookup of the common-anode glyph for each hex digit.
  always_comb begin
    seg_o = DISP_SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan with tear-free frame-boundary commit (DISP_LZS_EN: leading-zero suppression).
// Outputs registered; write visible within one frame plus one slot.
// No backpressure: every write is accepted, the last one before a frame tick wins.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = DISP_NUM_DIGITS,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic                    pending,
  output logic                    frame_tick,
  output disp_segment_t           seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4*NUM_DIGITS;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  scan_state_e           state_q, state_d;
  logic [DW-1:0]         shadow_q, shadow_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;
  disp_segment_t         seg_q, seg_d, dec_seg;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [NUM_DIGITS-1:0] blank_d;
  logic [3:0]            dec_nib;
  logic                  commit;

  // The shadow moves to the display only on the frame-tick cycle.
  assign commit    = frame_tick_q & pending_q;
  assign disp_d    = commit ? shadow_q : disp_q;
  assign disp_dp_d = commit ? shadow_dp_q : disp_dp_q;

`ifdef DISP_LZS_EN
  // Reset display is all zeros, so its mask blanks everything but digit 0.
  localparam logic [NUM_DIGITS-1:0] LZS_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  logic [NUM_DIGITS-1:0] lzs_q, lzs_new;
  logic                  zero_above;

  // Digit i is blanked when it and every higher nibble are zero; digit 0 never.
  always_comb begin
    lzs_new    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      zero_above = zero_above & (shadow_q[4*i +: 4] == 4'h0);
      lzs_new[i] = zero_above;
    end
  end

  // Suppression mask follows the display, captured at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lzs_q <= LZS_RST;
    else if (commit) lzs_q <= lzs_new;
  end

  assign blank_d = commit ? lzs_new : lzs_q;
`else
  assign blank_d = '0;
`endif

  // Slot counter, digit index, BLANK/SHOW sequencing and anode/tick decode.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV-1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS-1)) ? '0 : idx_q + IW'(1);
    end
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CW'(BLANK_CYC)) state_d = ST_SHOW;
      ST_SHOW:  if (cnt_d == '0)             state_d = ST_BLANK;
      default:                               state_d = ST_BLANK;
    endcase
    frame_tick_d = (cnt_d == CW'(SCAN_DIV-1)) && (idx_d == IW'(NUM_DIGITS-1));
    an_n_d       = (state_d == ST_SHOW) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
  end

  // Shadow capture; a write coinciding with commit stays pending for the next frame.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    if (commit) pending_d = 1'b0;
    if (wr_en) begin
      shadow_d    = wr_data;
      shadow_dp_d = wr_dp;
      pending_d   = 1'b1;
    end
  end

  assign dec_nib = disp_d[4*idx_d +: 4];

  DispDecoder u_dec (
    .nibble_i (dec_nib),
    .seg_o    (dec_seg)
  );

  // Segment data is only reloaded while the anodes are off.
  always_comb begin
    seg_d  = seg_q;
    dp_n_d = dp_n_q;
    if (state_d == ST_BLANK) begin
      seg_d  = blank_d[idx_d] ? DISP_SEG_BLANK : dec_seg;
      dp_n_d = blank_d[idx_d] | ~disp_dp_d[idx_d];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= DISP_SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Outputs sampled on the falling edge; cycle numbers count rising edges since reset release.
// Inputs driven on the falling edge, writes last exactly one cycle.
module tb_disp_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

`ifdef DISP_LZS_EN
  localparam logic LZS = 1'b1;
`else
  localparam logic LZS = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst_n, wr_en;
  logic [15:0]   wr_data;
  logic [ND-1:0] wr_dp;
  logic          pending, frame_tick;
  logic [6:0]    seg;
  logic          dp_n;
  logic [ND-1:0] an_n;

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [6:0] prev_seg;
  logic       prev_dpn;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .pending    (pending),
    .frame_tick (frame_tick),
    .seg        (seg),
    .dp_n       (dp_n),
    .an_n       (an_n)
  );

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn;
    logic        pend;
    logic        ft;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic w, logic [15:0] d, logic [3:0] p,
                              logic [3:0] a, logic [6:0] s, logic dn, logic pe, logic f);
    vec_t v;
    v.cyc = c; v.wr = w; v.data = d; v.dp = p;
    v.an = a; v.seg = s; v.dpn = dn; v.pend = pe; v.ft = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock; also checks that segments never move while an anode is driven.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    wr_en = 1'b0;
    if (rst_n && an_n != 4'hF) begin
      check("deadtime_seg", 32'(seg), 32'(prev_seg));
      check("deadtime_dp", 32'(dp_n), 32'(prev_dpn));
    end
    prev_seg = seg;
    prev_dpn = dp_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Write / commit table. Cycle c: cnt = c%8, idx = (c/8)%4, tick on c%32 == 31.
    vecs.push_back(mk( 70, 1, 16'h1A3F, 4'b0100, 4'b1110, S0, 1, 0, 0));
    vecs.push_back(mk( 71, 0, 16'h0000, 4'b0000, 4'b1110, S0, 1, 1, 0));
    vecs.push_back(mk( 95, 0, 16'h0000, 4'b0000, 4'b0111, S0, 1, 1, 1));
    vecs.push_back(mk( 96, 0, 16'h0000, 4'b0000, 4'b1111, SF, 1, 0, 0));
    vecs.push_back(mk( 98, 0, 16'h0000, 4'b0000, 4'b1110, SF, 1, 0, 0));
    vecs.push_back(mk(106, 0, 16'h0000, 4'b0000, 4'b1101, S3, 1, 0, 0));
    vecs.push_back(mk(114, 0, 16'h0000, 4'b0000, 4'b1011, SA, 0, 0, 0));
    vecs.push_back(mk(122, 0, 16'h0000, 4'b0000, 4'b0111, S1, 1, 0, 0));
    vecs.push_back(mk(124, 1, 16'h2222, 4'b0000, 4'b0111, S1, 1, 0, 0));
    vecs.push_back(mk(125, 0, 16'h0000, 4'b0000, 4'b0111, S1, 1, 1, 0));
    vecs.push_back(mk(127, 1, 16'h1111, 4'b0000, 4'b0111, S1, 1, 1, 1));
    vecs.push_back(mk(128, 0, 16'h0000, 4'b0000, 4'b1111, S2, 1, 1, 0));
    vecs.push_back(mk(130, 0, 16'h0000, 4'b0000, 4'b1110, S2, 1, 1, 0));
    vecs.push_back(mk(159, 0, 16'h0000, 4'b0000, 4'b0111, S2, 1, 1, 1));
    vecs.push_back(mk(160, 0, 16'h0000, 4'b0000, 4'b1111, S1, 1, 0, 0));
    vecs.push_back(mk(162, 1, 16'h0050, 4'b1000, 4'b1110, S1, 1, 0, 0));
    vecs.push_back(mk(163, 0, 16'h0000, 4'b0000, 4'b1110, S1, 1, 1, 0));
    vecs.push_back(mk(192, 0, 16'h0000, 4'b0000, 4'b1111, S0, 1, 0, 0));
    vecs.push_back(mk(194, 0, 16'h0000, 4'b0000, 4'b1110, S0, 1, 0, 0));
    vecs.push_back(mk(202, 0, 16'h0000, 4'b0000, 4'b1101, S5, 1, 0, 0));
    vecs.push_back(mk(210, 0, 16'h0000, 4'b0000, 4'b1011, LZS ? SB : S0, 1, 0, 0));
    vecs.push_back(mk(218, 0, 16'h0000, 4'b0000, 4'b0111, LZS ? SB : S0, LZS, 0, 0));
    vecs.push_back(mk(220, 1, 16'h0000, 4'b0000, 4'b0111, LZS ? SB : S0, LZS, 0, 0));
    vecs.push_back(mk(226, 0, 16'h0000, 4'b0000, 4'b1110, S0, 1, 0, 0));
    vecs.push_back(mk(234, 0, 16'h0000, 4'b0000, 4'b1101, LZS ? SB : S0, 1, 0, 0));

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0;
    repeat (2) @(negedge clk);
    check("rst_seg", 32'(seg), 32'(SB));
    check("rst_dpn", 32'(dp_n), 32'(1'b1));
    check("rst_an", 32'(an_n), 32'(4'hF));
    check("rst_pend", 32'(pending), 32'(1'b0));
    check("rst_ft", 32'(frame_tick), 32'(1'b0));
    rst_n = 1'b1;
    cyc = 0;
    prev_seg = seg;
    prev_dpn = dp_n;

    // Idle scan over two frames.
    for (int c = 0; c < 64; c++) begin
      logic [3:0] ea;
      int cnt, idx;
      if (c > 0) tick();
      cnt = c % SD;
      idx = (c / SD) % ND;
      ea = 4'hF;
      if (cnt >= BC) ea[idx] = 1'b0;
      check("idle_an", 32'(an_n), 32'(ea));
      check("idle_seg", 32'(seg), 32'((c == 0) ? SB : S0));
      check("idle_ft", 32'(frame_tick), 32'((cnt == SD-1) && (idx == ND-1)));
      check("idle_pend", 32'(pending), 32'(1'b0));
    end

    for (int k = 0; k < vecs.size(); k++) begin
      while (cyc < vecs[k].cyc) tick();
      check($sformatf("vec%0d_an", k), 32'(an_n), 32'(vecs[k].an));
      check($sformatf("vec%0d_seg", k), 32'(seg), 32'(vecs[k].seg));
      check($sformatf("vec%0d_dpn", k), 32'(dp_n), 32'(vecs[k].dpn));
      check($sformatf("vec%0d_pend", k), 32'(pending), 32'(vecs[k].pend));
      check($sformatf("vec%0d_ft", k), 32'(frame_tick), 32'(vecs[k].ft));
      if (vecs[k].wr) begin
        wr_en   = 1'b1;
        wr_data = vecs[k].data;
        wr_dp   = vecs[k].dp;
      end
    end

    // Reset during the SHOW of digit 2 with a write pending.
    while (cyc < 240) tick();
    wr_en = 1'b1; wr_data = 16'h9999; wr_dp = 4'hF;
    while (cyc < 243) tick();
    check("mid_pre_an", 32'(an_n), 32'(4'b1011));
    check("mid_pre_pend", 32'(pending), 32'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an_n), 32'(4'hF));
    check("mid_rst_seg", 32'(seg), 32'(SB));
    check("mid_rst_dpn", 32'(dp_n), 32'(1'b1));
    check("mid_rst_pend", 32'(pending), 32'(1'b0));
    check("mid_rst_ft", 32'(frame_tick), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    prev_seg = seg;
    prev_dpn = dp_n;
    tick();
    check("post_c1_an", 32'(an_n), 32'(4'hF));
    check("post_c1_seg", 32'(seg), 32'(S0));
    tick();
    check("post_c2_an", 32'(an_n), 32'(4'b1110));
    check("post_c2_seg", 32'(seg), 32'(S0));
    check("post_c2_dpn", 32'(dp_n), 32'(1'b1));
    while (cyc < 34) tick();
    check("post_f1_pend", 32'(pending), 32'(1'b0));
    check("post_f1_an", 32'(an_n), 32'(4'b1110));
    check("post_f1_seg", 32'(seg), 32'(S0));
    check("post_f1_dpn", 32'(dp_n), 32'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment bank in the MIPS32 IO subsystem. It latches a hex value written by the CPU IO path, commits it only at frame boundaries to prevent tearing, and steps through the digits one at a time. For each digit it inserts an anode-off dead time and drives the per-digit nibble through a `DispDecoder` instance.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned (2..8).
- `SCAN_DIV`, 50000: clock cycles per digit slot.
- `BLANK_CYC`, 500: dead-time cycles at the start of each slot; must satisfy 1 <= BLANK_CYC < SCAN_DIV.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `wr_en`  in  1  one-cycle write strobe from the IO decoder.
- `wr_data`  in  4*NUM_DIGITS  hex value; digit 0 (rightmost) = `wr_data[3:0]`.
- `wr_dp`  in  NUM_DIGITS  decimal-point enables, active-high, per digit.
- `pending`  out  1  shadow holds a value not yet committed.
- `frame_tick`  out  1  one-cycle pulse at the end of the last digit slot.
- `seg`  out  `DispSegment`  segments gfedcba, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  NUM_DIGITS  anode selects, active-low, one-hot-low or all-high.

## Operation
- Write: `wr_en`=1 loads `wr_data`/`wr_dp` into the shadow registers and sets `pending`=1. Back-to-back writes overwrite; the last one wins.
- Commit happens on the `frame_tick` cycle: if `pending`=1, the display registers take the shadow and `pending` clears.
- Write and commit in the same cycle: the commit uses the old shadow. The new write lands in the shadow and `pending` stays 1.
- Slot counter `cnt` runs 0..SCAN_DIV-1. Digit index `idx` runs 0..NUM_DIGITS-1 and increments when `cnt` wraps. `idx` wraps from NUM_DIGITS-1 back to 0, and that wrap cycle asserts `frame_tick`.
- Per-slot FSM:
  - BLANK (`cnt` < BLANK_CYC): `an_n` all 1; `seg`/`dp_n` already show the digit `idx`.
  - SHOW (`cnt` >= BLANK_CYC): `an_n[idx]`=0, all other bits 1.
  - Transition is BLANK->SHOW at `cnt`==BLANK_CYC and SHOW->BLANK at the `cnt` wrap.
- `seg` = registered `DispDecoder` output for the display nibble `idx`. `dp_n` = ~display_dp[`idx`].
- Blanked digit (see Configuration): `seg` all 1, `dp_n`=1, and its anode is still never driven during BLANK.

## Timing
- Reset values:
  - `seg` all 1, `dp_n`=1, `an_n` all 1.
  - `pending`=0, `frame_tick`=0.
  - `cnt`=0, `idx`=0, shadow and display registers 0, FSM in BLANK.
- The first SHOW after reset is digit 0, BLANK_CYC cycles after `rst_n` deasserts.
- All outputs are registered. `seg`/`dp_n` change only on the first cycle of BLANK, while all anodes are off.
- Frame period = NUM_DIGITS*SCAN_DIV cycles. Write-to-visible latency is at most one frame plus one slot.
- Reset asserted mid-frame: all outputs return to their reset values immediately. A pending write is discarded.

## Configuration
- `DISP_LZS_EN` defined: leading-zero suppression.
  - Digit i is blanked when its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - A blanked digit whose dp bit is set is still blanked.
  - The suppression mask is computed from the shadow and registered at commit.
- Not defined: all digits are always shown, including leading zeros.

## Structure
- Shared package/header: `DispSegment` width, `DISP_NUM_DIGITS` default, active-low blank pattern constant (7'b1111111).
- One sub-module: `DispDecoder` (existing nibble-to-segment decoder), instantiated once and fed by the idx-selected nibble. Its output is registered in this block.

## Test plan
Bench parameters are NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 unless stated otherwise.
- Reset then idle:
  - `an_n` cycles 1110, 1101, 1011, 0111, each low for 6 of 8 cycles, all-high for the other 2.
  - `seg`=1000000 on every digit.
  - `frame_tick` pulses every 32 cycles.
- Write 16'h1A3F mid-frame, `wr_dp`=4'b0100:
  - `pending`=1 until the next `frame_tick`, then clears.
  - Next frame shows digit0 `seg`=0001110, digit1 0110000, digit2 0001000 with `dp_n`=0, digit3 1111001.
- Write 16'h1111 on the `frame_tick` cycle with 16'h2222 already pending: 2222 is committed, `pending` stays 1, and 1111 is committed at the following tick.
- `DISP_LZS_EN`, write 16'h0050: digits 3 and 2 are blanked (`seg` all 1, `dp_n`=1); digit1 shows 0010010 and digit0 shows 1000000. A write of 16'h0000 shows only digit0 as 0.
- Assert `rst_n`=0 during a SHOW of digit 2 with a write pending: `an_n`/`seg` go all 1 asynchronously, `pending`=0, and after release digit 0 shows 0.
- Dead-time check: no cycle ever has `seg` changing while any `an_n` bit is 0.
